// File: rtl/way_set_pkg.sv
// Shared types for the way_set cache-set block: FSM states, op encoding, index-width helper.
// No logic; imported by every way_set file.
package way_set_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Encoded as {comp, write}
    typedef enum logic [1:0] {
        ACC_RD = 2'b00,
        ACC_WR = 2'b01,
        CMP_RD = 2'b10,
        CMP_WR = 2'b11
    } op_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/way_set_if.sv
// Request/response bundle between a requester and way_set.
// Latency: n/a (wires only). Backpressure: enable held until ack, then dropped.
interface way_set_if
    import way_set_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 16
) ();
    localparam int WAY_W  = idx_w(WAYS);
    localparam int WORD_W = idx_w(WORDS);

    logic              enable;
    logic              comp;
    logic              write;
    logic [WORD_W-1:0] word;
    logic [WAY_W-1:0]  way_in;
    logic [TAG_W-1:0]  tag_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_in;

    logic              hit;
    logic              dirty_out;
    logic              valid_out;
    logic [TAG_W-1:0]  tag_out;
    logic [DATA_W-1:0] data_out;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    logic              ack;

    modport master (
        output enable, comp, write, word, way_in, tag_in, data_in, valid_in,
        input  hit, dirty_out, valid_out, tag_out, data_out, hit_way, victim_way, ack
    );

    modport slave (
        input  enable, comp, write, word, way_in, tag_in, data_in, valid_in,
        output hit, dirty_out, valid_out, tag_out, data_out, hit_way, victim_way, ack
    );

endinterface

// File: rtl/way_set_set_way.sv
// One way of the set: tag/valid/dirty plus WORDS data words, with tag-match output.
// Latency: writes land on the next rising edge; match/read are combinational. No backpressure.
module set_way
    import way_set_pkg::*;
#(
    parameter int  WORDS  = 4,
    parameter int  TAG_W  = 5,
    parameter int  DATA_W = 16,
    localparam int WORD_W = idx_w(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_meta,
    input  logic              wr_word,
    input  logic              set_dirty,
    input  logic [WORD_W-1:0] word,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [TAG_W-1:0]  cmp_tag,
    output logic              match,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] rdata
);

    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              valid_q, valid_d;
    logic              dirty_q, dirty_d;
    logic [DATA_W-1:0] words_q [WORDS];
    logic [DATA_W-1:0] words_d [WORDS];

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        words_d = words_q;
        if (wr_meta) begin
            tag_d   = tag_in;
            valid_d = valid_in;
            dirty_d = 1'b0;
        end
        if (set_dirty) dirty_d = 1'b1;
        if (wr_word) words_d[word] = data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data array is deliberately not reset; write enables are already gated off by reset.
    always_ff @(posedge clk) begin
        words_q <= words_d;
    end

    assign match = valid_q && (tag_q == cmp_tag);
    assign valid = valid_q;
    assign dirty = dirty_q;
    assign tag   = tag_q;
    assign rdata = words_q[word];

endmodule

// File: rtl/way_set.sv
// N-way cache set: compare (tag lookup) and access (direct way) read/write ops; WAY_SET_LRU_EN picks LRU over round-robin.
// Latency: ack 2 edges after enable is sampled (IDLE->LOOKUP->DONE). Backpressure: ack held while enable high.
module way_set
    import way_set_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 16
) (
    input  logic clk,
    input  logic rst,
    way_set_if.slave bus
);

    localparam int WAY_W  = idx_w(WAYS);
    localparam int WORD_W = idx_w(WORDS);

    state_e            state_q, state_d;
    op_e               req_op_q, req_op_d;
    logic [WORD_W-1:0] req_word_q, req_word_d;
    logic [WAY_W-1:0]  req_way_q, req_way_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              req_valid_q, req_valid_d;

    logic              hit_q, hit_d;
    logic              dirty_out_q, dirty_out_d;
    logic              valid_out_q, valid_out_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [WAY_W-1:0]  hit_way_q, hit_way_d;
    logic [WAY_W-1:0]  victim_way_q, victim_way_d;

    logic [WAYS-1:0]   wr_meta, wr_word, set_dirty;
    logic [WAYS-1:0]   way_match, way_valid, way_dirty;
    logic [TAG_W-1:0]  way_tag   [WAYS];
    logic [DATA_W-1:0] way_rdata [WAYS];

    logic              hit_any, inv_any;
    logic [WAY_W-1:0]  hit_idx, inv_idx, pol_idx, victim;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        set_way #(.WORDS(WORDS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
            .clk       (clk),
            .rst       (rst),
            .wr_meta   (wr_meta[g]),
            .wr_word   (wr_word[g]),
            .set_dirty (set_dirty[g]),
            .word      (req_word_q),
            .tag_in    (req_tag_q),
            .valid_in  (req_valid_q),
            .data_in   (req_data_q),
            .cmp_tag   (req_tag_q),
            .match     (way_match[g]),
            .valid     (way_valid[g]),
            .dirty     (way_dirty[g]),
            .tag       (way_tag[g]),
            .rdata     (way_rdata[g])
        );
    end

    // Descending scan so the lowest index wins on multiple matches / multiple invalid ways.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_match[i]) begin
                hit_any = 1'b1;
                hit_idx = WAY_W'(i);
            end
            if (!way_valid[i]) begin
                inv_any = 1'b1;
                inv_idx = WAY_W'(i);
            end
        end
        victim = inv_any ? inv_idx : pol_idx;
    end

`ifdef WAY_SET_LRU_EN
    // Ages form a permutation of 0..WAYS-1; 0 is most recent, WAYS-1 is the LRU way.
    logic [WAY_W-1:0] age_q [WAYS];
    logic [WAY_W-1:0] age_d [WAYS];
    logic             touch_en;
    logic [WAY_W-1:0] touch_idx;

    always_comb begin
        touch_en  = (state_q == LOOKUP) &&
                    ((req_op_q == ACC_WR) || (((req_op_q == CMP_RD) || (req_op_q == CMP_WR)) && hit_any));
        touch_idx = (req_op_q == ACC_WR) ? req_way_q : hit_idx;
        age_d     = age_q;
        pol_idx   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == WAY_W'(WAYS - 1)) pol_idx = WAY_W'(i);
            if (touch_en) begin
                if (WAY_W'(i) == touch_idx)           age_d[i] = '0;
                else if (age_q[i] < age_q[touch_idx]) age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++) age_q[i] <= WAY_W'(WAYS - 1 - i);
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic [WAY_W-1:0] rr_q, rr_d;

    always_comb begin
        rr_d    = rr_q;
        pol_idx = rr_q;
        if ((state_q == LOOKUP) && (req_op_q == ACC_WR))
            rr_d = (rr_q == WAY_W'(WAYS - 1)) ? '0 : rr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end
`endif

    always_comb begin
        wr_meta   = '0;
        wr_word   = '0;
        set_dirty = '0;
        if (state_q == LOOKUP) begin
            case (req_op_q)
                ACC_WR: begin
                    wr_meta[req_way_q] = 1'b1;
                    wr_word[req_way_q] = 1'b1;
                end
                CMP_WR: if (hit_any) begin
                    wr_word[hit_idx]   = 1'b1;
                    set_dirty[hit_idx] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        req_op_d     = req_op_q;
        req_word_d   = req_word_q;
        req_way_d    = req_way_q;
        req_tag_d    = req_tag_q;
        req_data_d   = req_data_q;
        req_valid_d  = req_valid_q;
        hit_d        = hit_q;
        dirty_out_d  = dirty_out_q;
        valid_out_d  = valid_out_q;
        tag_out_d    = tag_out_q;
        data_out_d   = data_out_q;
        hit_way_d    = hit_way_q;
        victim_way_d = victim_way_q;
        case (state_q)
            IDLE: if (bus.enable) begin
                state_d     = LOOKUP;
                req_op_d    = op_e'({bus.comp, bus.write});
                req_word_d  = bus.word;
                req_way_d   = bus.way_in;
                req_tag_d   = bus.tag_in;
                req_data_d  = bus.data_in;
                req_valid_d = bus.valid_in;
            end
            LOOKUP: begin
                state_d = DONE;
                case (req_op_q)
                    CMP_RD, CMP_WR: begin
                        hit_d = hit_any;
                        if (hit_any) begin
                            hit_way_d   = hit_idx;
                            valid_out_d = way_valid[hit_idx];
                            tag_out_d   = way_tag[hit_idx];
                            dirty_out_d = (req_op_q == CMP_RD) ? way_dirty[hit_idx] : 1'b0;
                            if (req_op_q == CMP_RD) data_out_d = way_rdata[hit_idx];
                        end else begin
                            valid_out_d = way_valid[victim];
                            dirty_out_d = way_dirty[victim];
                            tag_out_d   = way_tag[victim];
                        end
                    end
                    ACC_RD: begin
                        hit_d       = 1'b0;
                        valid_out_d = way_valid[req_way_q];
                        dirty_out_d = way_dirty[req_way_q];
                        tag_out_d   = way_tag[req_way_q];
                        data_out_d  = way_rdata[req_way_q];
                    end
                    default: hit_d = 1'b0;
                endcase
            end
            DONE: begin
                // Storage and policy were updated entering DONE, so victim reflects this op.
                victim_way_d = victim;
                if (!bus.enable) begin
                    state_d = IDLE;
                    hit_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_op_q     <= ACC_RD;
            req_word_q   <= '0;
            req_way_q    <= '0;
            req_tag_q    <= '0;
            req_data_q   <= '0;
            req_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            dirty_out_q  <= 1'b0;
            valid_out_q  <= 1'b0;
            tag_out_q    <= '0;
            data_out_q   <= '0;
            hit_way_q    <= '0;
            victim_way_q <= '0;
        end else begin
            state_q      <= state_d;
            req_op_q     <= req_op_d;
            req_word_q   <= req_word_d;
            req_way_q    <= req_way_d;
            req_tag_q    <= req_tag_d;
            req_data_q   <= req_data_d;
            req_valid_q  <= req_valid_d;
            hit_q        <= hit_d;
            dirty_out_q  <= dirty_out_d;
            valid_out_q  <= valid_out_d;
            tag_out_q    <= tag_out_d;
            data_out_q   <= data_out_d;
            hit_way_q    <= hit_way_d;
            victim_way_q <= victim_way_d;
        end
    end

    assign bus.ack        = (state_q == DONE);
    assign bus.hit        = hit_q;
    assign bus.dirty_out  = dirty_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.tag_out    = tag_out_q;
    assign bus.data_out   = data_out_q;
    assign bus.hit_way    = hit_way_q;
    assign bus.victim_way = victim_way_q;

endmodule
